// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU select codes, divider state encoding and width default
package alu_defs;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_DIV  = 5'b11100;
    localparam logic [4:0] ALU_REM  = 5'b11101;
    localparam logic [4:0] ALU_DIVU = 5'b11110;
    localparam logic [4:0] ALU_REMU = 5'b11111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // All divide/remainder ops share the 111xx prefix.
    function automatic logic is_div_op(input logic [4:0] sel);
        return sel[4:2] == 3'b111;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-divide iteration
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          unused_rem_msb;

    // rem < div holds between steps, so the shifted value stays below 2*div
    // and the top bit of the difference is the borrow.
    assign shifted        = {rem[XLEN-1:0], quo[XLEN-1]};
    assign diff           = shifted - {1'b0, div};
    assign rem_next       = diff[XLEN] ? shifted : diff;
    assign quo_next       = {quo[XLEN-2:0], ~diff[XLEN]};
    assign unused_rem_msb = rem[XLEN];

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divide/remainder sequencer for the ALU
module div_sequencer
    import alu_defs::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      select,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   STEPS_C = CW'(STEPS);

    div_state_t      state, state_next;
    logic [XLEN:0]   rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_dec;
    logic            op_rem;
    logic            neg_quo;
    logic            neg_rem;

    logic            accept;
    logic            is_signed;
    logic            sign1, sign2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] quo_fix, rem_fix, final_result;

    logic [XLEN:0]   rem_chain [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] quo_chain [0:BITS_PER_CYCLE];

    assign accept    = (state == IDLE) && start && is_div_op(select);
    assign is_signed = ~select[1];
    assign sign1     = is_signed & data1[XLEN-1];
    assign sign2     = is_signed & data2[XLEN-1];
    assign abs1      = sign1 ? (~data1 + ONE) : data1;
    assign abs2      = sign2 ? (~data2 + ONE) : data2;
    assign div_zero  = (data2 == '0);
    assign overflow  = is_signed && (data1 == INT_MIN) && (data2 == '1);
    assign special   = div_zero || overflow;

    // Div-by-zero returns the raw dividend as remainder, not its magnitude.
    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = select[0] ? data1 : '1;
        else
            special_result = select[0] ? '0 : INT_MIN;
    end

    assign rem_chain[0] = rem_r;
    assign quo_chain[0] = quo_r;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem      (rem_chain[g]),
            .quo      (quo_chain[g]),
            .div      (dvs_r),
            .rem_next (rem_chain[g+1]),
            .quo_next (quo_chain[g+1])
        );
    end

    assign cnt_dec      = cnt - CW'(1);
    assign quo_fix      = neg_quo ? (~quo_chain[BITS_PER_CYCLE] + ONE) : quo_chain[BITS_PER_CYCLE];
    assign rem_fix      = neg_rem ? (~rem_chain[BITS_PER_CYCLE][XLEN-1:0] + ONE)
                                  : rem_chain[BITS_PER_CYCLE][XLEN-1:0];
    assign final_result = op_rem ? rem_fix : quo_fix;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? FINISH : CALC;
            CALC:    if (cnt_dec == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            cnt     <= '0;
            op_rem  <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_rem  <= select[0];
                neg_quo <= sign1 ^ sign2;
                neg_rem <= sign1;
                rem_r   <= '0;
                quo_r   <= abs1;
                dvs_r   <= abs2;
                cnt     <= STEPS_C;
                if (special)
                    result <= special_result;
            end else if (state == CALC) begin
                rem_r <= rem_chain[BITS_PER_CYCLE];
                quo_r <= quo_chain[BITS_PER_CYCLE];
                cnt   <= cnt_dec;
                if (cnt_dec == '0)
                    result <= final_result;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  select;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    div_sequencer #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .select (select),
        .data1  (data1),
        .data2  (data2),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge is cycle 0; the cycle after edge k is cycle k+1.
    task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_cycle, input int poke);
        int   cyc;
        int   busy_cnt;
        logic seen;
        start  = 1'b1;
        select = sel;
        data1  = a;
        data2  = b;
        tick();
        start  = 1'b0;
        select = 5'b0;
        data1  = 32'd0;
        data2  = 32'd0;
        cyc      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cyc <= 100) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (cyc == poke) begin
                    start  = 1'b1;
                    select = ALU_DIV;
                    data1  = 32'd9;
                    data2  = 32'd3;
                end else begin
                    start  = 1'b0;
                    select = 5'b0;
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, " done"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_cycle));
        check({tag, " result"}, result, exp_res);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_cycle));
        tick();
        check({tag, " idle after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        int cyc;
        reset  = 1'b1;
        start  = 1'b0;
        select = 5'b0;
        data1  = 32'd0;
        data2  = 32'd0;
        tick();
        tick();
        check("reset result", result, 32'd0);
        check("reset busy/done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        tick();

        run_op("rem 27,5",   ALU_REM,  32'd27,         32'd5,         32'd2,          33, 0);
        run_op("div -7,2",   ALU_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD,  33, 0);
        run_op("rem -7,2",   ALU_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  33, 0);
        run_op("divu big,3", ALU_DIVU, 32'hFFFF_FFFE,  32'd3,         32'h5555_5554,  33, 0);
        run_op("remu big,3", ALU_REMU, 32'hFFFF_FFFE,  32'd3,         32'd2,          33, 0);
        run_op("div 10,0",   ALU_DIV,  32'd10,         32'd0,         32'hFFFF_FFFF,  1,  0);
        run_op("rem 10,0",   ALU_REM,  32'd10,         32'd0,         32'd10,         1,  0);
        run_op("div ovf",    ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1,  0);
        run_op("rem ovf",    ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          1,  0);

        // A START while busy must be dropped, not queued.
        run_op("div 10,2 poke", ALU_DIV, 32'd10, 32'd2, 32'd5, 33, 5);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        check("no queued start", 32'(dones), 32'd0);

        start  = 1'b1;
        select = 5'b00000;
        data1  = 32'd5;
        data2  = 32'd1;
        tick();
        start = 1'b0;
        check("non-div select busy", {30'd0, busy, done}, 32'd0);
        tick();
        check("non-div select later", {30'd0, busy, done}, 32'd0);
        check("non-div result held", result, 32'd5);

        start  = 1'b1;
        select = ALU_DIV;
        data1  = 32'd100;
        data2  = 32'd7;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            tick();
            cyc++;
        end
        check("busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("abort result", result, 32'd0);
        check("abort busy/done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        tick();
        run_op("div 100,7", ALU_DIV, 32'd100, 32'd7, 32'd14, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
